// File: rtl/ov7670_timing_gen_pkg.sv
// Shared types and constants for the OV7670-style timing source.
// Holds the FSM state encoding, colour-bar table and default VGA timing.
package ov7670_timing_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_VSYNC,
    ST_VBP,
    ST_ACTIVE,
    ST_VFP
  } state_t;

  // RGB565 colour bars, left to right
  localparam logic [15:0] BAR_RGB [8] = '{
    16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
    16'hF81F, 16'hF800, 16'h001F, 16'h0000
  };

  localparam int DEF_CLK_DIV       = 2;
  localparam int DEF_H_ACTIVE      = 640;
  localparam int DEF_H_BLANK_BYTES = 288;
  localparam int DEF_V_ACTIVE      = 480;
  localparam int DEF_VSYNC_LINES   = 3;
  localparam int DEF_VBP_LINES     = 17;
  localparam int DEF_VFP_LINES     = 10;

  // Bits needed to count 0..n-1, never less than one
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ov7670_timing_gen_if.sv
// Camera-side sensor bus: control inputs plus PCLK/VSYNC/HREF/D outputs.
// master = the timing source, slave = the capture side.
interface ov7670_timing_gen_if;
  logic       i_en;
  logic       i_pattern;
  logic       o_pclk;
  logic       o_vsync;
  logic       o_href;
  logic [7:0] o_data;
  logic       o_frame_done;

  modport master (
    input  i_en, i_pattern,
    output o_pclk, o_vsync, o_href, o_data, o_frame_done
  );

  modport slave (
    output i_en, i_pattern,
    input  o_pclk, o_vsync, o_href, o_data, o_frame_done
  );
endinterface

// File: rtl/ov7670_timing_gen_pclk_gen.sv
// Pixel clock divider: o_pclk toggles every CLK_DIV i_clk cycles.
// o_tick marks the i_clk cycle at whose end o_pclk falls.
module pclk_gen
  import ov7670_timing_pkg::*;
#(
  parameter int CLK_DIV = DEF_CLK_DIV
) (
  input  logic i_clk,
  input  logic i_reset,
  output logic o_pclk,
  output logic o_tick
);

  localparam int DW = cnt_w(CLK_DIV);
  localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);

  logic [DW-1:0] div_cnt;
  logic          wrap;

  assign wrap   = (div_cnt == DIV_MAX);
  assign o_tick = wrap & o_pclk;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      div_cnt <= '0;
      o_pclk  <= 1'b0;
    end else if (wrap) begin
      div_cnt <= '0;
      o_pclk  <= ~o_pclk;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/ov7670_timing_gen.sv
// OV7670-style frame timing source: VSYNC/HREF/D[7:0] driven off PCLK falling edges.
// Generates a byte ramp or 8 RGB565 colour bars per line.
//
// state     | meaning
// ST_IDLE   | outputs low, waiting for i_en on a tick
// ST_VSYNC  | VSYNC_LINES lines with o_vsync high
// ST_VBP    | VBP_LINES blank lines after vsync
// ST_ACTIVE | V_ACTIVE lines, HREF high for the first 2*H_ACTIVE bytes
// ST_VFP    | VFP_LINES blank lines, then frame done
module ov7670_timing_gen
  import ov7670_timing_pkg::*;
#(
  parameter int CLK_DIV       = DEF_CLK_DIV,
  parameter int H_ACTIVE      = DEF_H_ACTIVE,
  parameter int H_BLANK_BYTES = DEF_H_BLANK_BYTES,
  parameter int V_ACTIVE      = DEF_V_ACTIVE,
  parameter int VSYNC_LINES   = DEF_VSYNC_LINES,
  parameter int VBP_LINES     = DEF_VBP_LINES,
  parameter int VFP_LINES     = DEF_VFP_LINES
) (
  input logic                  i_clk,
  input logic                  i_reset,
  ov7670_timing_gen_if.master  cam
);

  localparam int LINE       = 2 * H_ACTIVE + H_BLANK_BYTES;
  localparam int HREF_END   = 2 * H_ACTIVE;
  localparam int LC_MAX     = max_int(max_int(V_ACTIVE, VSYNC_LINES),
                                      max_int(VBP_LINES, VFP_LINES));
  localparam int PX_PER_BAR = H_ACTIVE / 8;
  localparam int BC_W       = cnt_w(LINE);
  localparam int LC_W       = cnt_w(LC_MAX);
  localparam int PX_W       = cnt_w(PX_PER_BAR);

  logic tick;

  pclk_gen #(.CLK_DIV(CLK_DIV)) u_pclk_gen (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .o_pclk  (cam.o_pclk),
    .o_tick  (tick)
  );

  state_t          state, state_n;
  logic [BC_W-1:0] bc, bc_n;
  logic [LC_W-1:0] lc, lc_n;
  logic [PX_W-1:0] px, px_n;
  logic [2:0]      bar, bar_n;
  logic            pat_sel, pat_n;
  logic            frame_end;
  logic            line_end;
  logic            href_n;
  logic [7:0]      data_n;
  logic [15:0]     bar_rgb;
  logic [7:0]      bc_lo;
  logic            vsync_q, href_q, done_q;
  logic [7:0]      data_q;

  assign line_end = (bc == BC_W'(LINE - 1));

  always_comb begin
    state_n   = state;
    bc_n      = bc;
    lc_n      = lc;
    pat_n     = pat_sel;
    frame_end = 1'b0;
    if (state == ST_IDLE) begin
      bc_n = '0;
      lc_n = '0;
      if (cam.i_en) begin
        state_n = ST_VSYNC;
        pat_n   = cam.i_pattern;
      end
    end else begin
      bc_n = line_end ? '0 : bc + 1'b1;
      if (line_end) begin
        lc_n = lc + 1'b1;
        unique case (state)
          ST_VSYNC: if (lc == LC_W'(VSYNC_LINES - 1)) begin
            state_n = ST_VBP;
            lc_n    = '0;
          end
          ST_VBP: if (lc == LC_W'(VBP_LINES - 1)) begin
            state_n = ST_ACTIVE;
            lc_n    = '0;
          end
          ST_ACTIVE: if (lc == LC_W'(V_ACTIVE - 1)) begin
            state_n = ST_VFP;
            lc_n    = '0;
          end
          ST_VFP: if (lc == LC_W'(VFP_LINES - 1)) begin
            frame_end = 1'b1;
            lc_n      = '0;
            if (cam.i_en) begin
              state_n = ST_VSYNC;
              pat_n   = cam.i_pattern;
            end else begin
              state_n = ST_IDLE;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Bar index advances every PX_PER_BAR pixels instead of dividing x
  always_comb begin
    px_n  = px;
    bar_n = bar;
    if (bc_n == '0) begin
      px_n  = '0;
      bar_n = '0;
    end else if (!bc_n[0] && (int'(bc_n) < HREF_END)) begin
      if (px == PX_W'(PX_PER_BAR - 1)) begin
        px_n  = '0;
        bar_n = bar + 1'b1;
      end else begin
        px_n = px + 1'b1;
      end
    end
  end

  always_comb begin
    bar_rgb = BAR_RGB[bar_n];
    bc_lo   = 8'(bc_n);
    href_n  = (state_n == ST_ACTIVE) && (int'(bc_n) < HREF_END);
    data_n  = 8'h00;
    if (href_n) begin
      if (pat_n) data_n = bc_n[0] ? bar_rgb[7:0] : bar_rgb[15:8];
      else       data_n = bc_lo;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state   <= ST_IDLE;
      bc      <= '0;
      lc      <= '0;
      px      <= '0;
      bar     <= '0;
      pat_sel <= 1'b0;
      vsync_q <= 1'b0;
      href_q  <= 1'b0;
      data_q  <= 8'h00;
      done_q  <= 1'b0;
    end else begin
      done_q <= tick & frame_end;
      if (tick) begin
        state   <= state_n;
        bc      <= bc_n;
        lc      <= lc_n;
        px      <= px_n;
        bar     <= bar_n;
        pat_sel <= pat_n;
        vsync_q <= (state_n == ST_VSYNC);
        href_q  <= href_n;
        data_q  <= data_n;
      end
    end
  end

  assign cam.o_vsync      = vsync_q;
  assign cam.o_href       = href_q;
  assign cam.o_data       = data_q;
  assign cam.o_frame_done = done_q;

endmodule

// File: tb/tb_ov7670_timing_gen.sv
// Scoreboard bench for ov7670_timing_gen at a tiny 8x4 frame size.
// Stimulus queues expected bytes per frame; a PCLK-edge monitor pops and compares.
module tb_ov7670_timing_gen;

  localparam int LINE      = 20;
  localparam int BURST     = 16;
  localparam int HBLANK    = 4;
  localparam int FRAME_CLK = 560;
  localparam int CLK_PER   = 10;

  logic i_clk   = 1'b0;
  logic i_reset = 1'b1;

  ov7670_timing_gen_if cam();

  ov7670_timing_gen #(
    .CLK_DIV(2), .H_ACTIVE(8), .H_BLANK_BYTES(4), .V_ACTIVE(4),
    .VSYNC_LINES(1), .VBP_LINES(1), .VFP_LINES(1)
  ) dut (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .cam     (cam)
  );

  always #5 i_clk = ~i_clk;

  int total = 0;
  int bad   = 0;
  logic [7:0] exp_q[$];
  logic [7:0] bar_bytes [16] = '{
    8'hFF, 8'hFF, 8'hFF, 8'hE0, 8'h07, 8'hFF, 8'h07, 8'hE0,
    8'hF8, 8'h1F, 8'hF8, 8'h00, 8'h00, 8'h1F, 8'h00, 8'h00
  };

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_ramp();
    for (int l = 0; l < 4; l++)
      for (int b = 0; b < BURST; b++) exp_q.push_back(8'(b));
  endtask

  task automatic push_bars();
    for (int l = 0; l < 4; l++)
      for (int b = 0; b < BURST; b++) exp_q.push_back(bar_bytes[b]);
  endtask

  task automatic wait_done(output time t);
    bit found = 1'b0;
    t = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge i_clk);
      if (cam.o_frame_done) begin
        found = 1'b1;
        t     = $time;
        break;
      end
    end
    check("done_seen", int'(found), 1);
  endtask

  task automatic wait_href();
    bit found = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge i_clk);
      if (cam.o_href) begin
        found = 1'b1;
        break;
      end
    end
    check("href_seen", int'(found), 1);
  endtask

  // Monitor: every PCLK rising edge is an observation point
  logic prev_pclk = 1'b0;
  logic prev_done = 1'b0;
  int   href_run = 0, vs_run = 0, gap_cnt = 0, blank_cnt = 0;
  bit   gap_on = 1'b0, blank_on = 1'b0;

  always @(negedge i_clk) begin
    if (i_reset) begin
      prev_pclk = 1'b0;
      prev_done = 1'b0;
      href_run  = 0;
      vs_run    = 0;
      gap_on    = 1'b0;
      blank_on  = 1'b0;
    end else begin
      if (prev_done) check("done_width", int'(cam.o_frame_done), 0);
      prev_done = cam.o_frame_done;
      if (cam.o_pclk && !prev_pclk) begin
        if (cam.o_href) begin
          if (gap_on) begin
            check("vbp_pclks", gap_cnt, LINE);
            gap_on = 1'b0;
          end
          if (blank_on) begin
            check("hblank_pclks", blank_cnt, HBLANK);
            blank_on = 1'b0;
          end
          href_run++;
          check("queue_nonempty", int'(exp_q.size() > 0), 1);
          if (exp_q.size() > 0) check("data", int'(cam.o_data), int'(exp_q.pop_front()));
        end else begin
          check("data_zero_no_href", int'(cam.o_data), 0);
          if (href_run > 0) begin
            check("href_len", href_run, BURST);
            href_run  = 0;
            blank_on  = 1'b1;
            blank_cnt = 0;
          end
          if (blank_on) blank_cnt++;
        end
        if (cam.o_vsync) begin
          vs_run++;
          blank_on = 1'b0;
        end else if (vs_run > 0) begin
          check("vsync_len", vs_run, LINE);
          vs_run  = 0;
          gap_on  = 1'b1;
          gap_cnt = 0;
        end
        if (gap_on) gap_cnt++;
      end
      prev_pclk = cam.o_pclk;
    end
  end

  initial begin
    logic s [24];
    int   toggles, viol, highs;
    time  ta, tb, tc;

    cam.i_en      = 1'b0;
    cam.i_pattern = 1'b0;
    repeat (3) @(negedge i_clk);
    check("rst_pclk", int'(cam.o_pclk), 0);
    check("rst_vsync", int'(cam.o_vsync), 0);
    check("rst_href", int'(cam.o_href), 0);
    check("rst_data", int'(cam.o_data), 0);
    check("rst_done", int'(cam.o_frame_done), 0);
    i_reset = 1'b0;

    for (int i = 0; i < 24; i++) begin
      @(negedge i_clk);
      s[i] = cam.o_pclk;
    end
    toggles = 0;
    viol    = 0;
    for (int i = 1; i < 24; i++) if (s[i] != s[i-1]) toggles++;
    for (int i = 2; i < 24; i++) if (s[i] == s[i-2]) viol++;
    check("pclk_toggles", toggles, 12);
    check("pclk_half_period", viol, 0);

    highs = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge i_clk);
      if (cam.o_vsync || cam.o_href) highs++;
    end
    check("idle_quiet_en0", highs, 0);

    // frame A ramp, B bars, C ramp with i_en dropped mid-ACTIVE
    push_ramp();
    cam.i_pattern = 1'b0;
    cam.i_en      = 1'b1;
    wait_href();
    cam.i_pattern = 1'b1;
    push_bars();
    wait_done(ta);
    check("vsync_no_gap_a", int'(cam.o_vsync), 1);
    cam.i_pattern = 1'b0;
    push_ramp();
    wait_done(tb);
    check("frame_period_b", int'((tb - ta) / CLK_PER), FRAME_CLK);
    check("vsync_no_gap_b", int'(cam.o_vsync), 1);
    wait_href();
    cam.i_en = 1'b0;
    wait_done(tc);
    check("frame_period_c", int'((tc - tb) / CLK_PER), FRAME_CLK);
    check("idle_after_done", int'(cam.o_vsync), 0);
    highs = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge i_clk);
      if (cam.o_vsync || cam.o_href || cam.o_frame_done || cam.o_data != 0) highs++;
    end
    check("idle_quiet_after", highs, 0);
    check("queue_drained_c", exp_q.size(), 0);

    // reset mid-HREF, then a clean restart
    push_ramp();
    cam.i_en = 1'b1;
    wait_href();
    repeat (6) @(negedge i_clk);
    check("href_before_reset", int'(cam.o_href), 1);
    i_reset = 1'b1;
    #1;
    check("async_rst_href", int'(cam.o_href), 0);
    check("async_rst_vsync", int'(cam.o_vsync), 0);
    check("async_rst_data", int'(cam.o_data), 0);
    check("async_rst_pclk", int'(cam.o_pclk), 0);
    cam.i_en = 1'b0;
    exp_q.delete();
    repeat (2) @(negedge i_clk);
    push_ramp();
    cam.i_en = 1'b1;
    i_reset  = 1'b0;
    wait_href();
    cam.i_en = 1'b0;
    wait_done(ta);
    check("queue_drained_restart", exp_q.size(), 0);
    repeat (20) @(negedge i_clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
